if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage of the 5-stage pipelined CPU. It owns the program counter, selects the next PC (sequential, branch, jump, exception vector), and drives the instruction-memory request and ready handshake. Each cycle it presents an instruction and its PC+4 to the IF/ID pipeline register. When no valid instruction is available, it presents a NOP bubble.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- EXC_VECTOR, 32'h8000_0180, PC loaded on exception

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  asynchronous, active-low reset
- stall  in  1  hazard unit hold request; IF/ID keeps its contents
- branch_taken  in  1  branch resolved taken in ID
- branch_target  in  32  branch destination
- jump  in  1  jump in ID
- jump_target  in  32  jump destination
- exception  in  1  exception redirect request
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address; always equals the PC register
- imem_ready  in  1  imem_rdata is valid this cycle
- imem_rdata  in  32  fetched word
- out_valid  out  1  out_inst and out_PCplus4 carry a real instruction
- out_inst  out  32  instruction to IF/ID in_inst
- out_PCplus4  out  32  PC+4 to IF/ID in_PCplus4

## Operation
- Registers:
  - pc[31:0]
  - hold_buf[31:0]
  - state in {BOOT, FETCH, HELD}
- All target and vector values are written to pc with bits [1:0] forced to 00.
- Bubble output, used whenever out_valid=0:
  - out_inst = 32'h2000_0000 (addi $0,$0,0)
  - out_PCplus4 = 32'hFFFF_FFFF
- Valid output:
  - out_PCplus4 = pc + 4, wrapping modulo 2^32 (pc=32'hFFFF_FFFC gives 0).
  - out_inst = imem_rdata in FETCH, hold_buf in HELD.
- Next-PC priority within every state: exception > stall > branch_taken > jump > sequential.
- BOOT:
  - imem_req=0, out_valid=0.
  - Next state is always FETCH; pc keeps RESET_PC.
  - Exception still loads EXC_VECTOR.
- FETCH:
  - imem_req=1.
  - out_valid = imem_ready & ~exception.
  - exception: pc<=EXC_VECTOR; stay in FETCH. The current word is squashed.
  - stall & imem_ready: hold_buf<=imem_rdata; pc held; go to HELD.
  - stall & ~imem_ready: pc held; stay in FETCH.
  - branch_taken: pc<=branch_target. The current word, if ready, is delivered as the delay slot.
  - jump: pc<=jump_target.
  - imem_ready otherwise: pc<=pc+4.
  - ~imem_ready otherwise: pc held; output is a bubble.
- HELD:
  - imem_req=0, out_valid=~exception, output taken from hold_buf.
  - exception: pc<=EXC_VECTOR; go to FETCH.
  - stall: no change.
  - branch_taken or jump: pc<=target; go to FETCH.
  - otherwise: pc<=pc+4; go to FETCH.
- Memory is never re-read for a word already captured in hold_buf.
- branch_taken and jump asserted together: branch wins.

## Timing
- Reset value of every register and output, while RESET=0:
  - pc=RESET_PC, state=BOOT, hold_buf=32'h2000_0000
  - imem_req=0, imem_addr=RESET_PC, out_valid=0, bubble outputs
- Reset takes effect immediately, without a clock edge, including in the middle of a fetch, stall or hold.
- First request: imem_req rises in the first cycle after the first rising edge following RESET deassertion.
- Outputs are combinational from state, pc, hold_buf and imem_* in the same cycle; IF/ID registers them.
- Zero-wait memory: one instruction per cycle; pc advances on every edge.
- Redirect latency: a redirect sampled at edge N gives imem_addr = target in the cycle after edge N.
- No combinational path from imem_rdata to imem_req or imem_addr.

## Test plan
- Reset then run, imem_ready=1 and rdata=addr: after release, one BOOT cycle with a bubble. Then imem_addr = 0, 4, 8, … with out_PCplus4 = 4, 8, 12, … and out_valid=1.
- Wait states, imem_ready low for 2 cycles at pc=8: two cycles of out_valid=0 with out_inst=32'h2000_0000 and out_PCplus4=32'hFFFF_FFFF. pc stays 8, then the word at 8 is delivered once.
- Stall 3 cycles with ready at pc=0x10:
  - hold_buf captures the word; imem_req=0 during HELD.
  - out_inst stays constant with out_PCplus4=0x14 throughout.
  - After release, imem_addr=0x14.
- Branch at pc=0x20 with target 0x103:
  - The 0x20 word is delivered valid.
  - Next imem_addr=0x100.
  - branch_taken+jump together: branch_target is used.
- Exception during stall in HELD: out_valid=0 that cycle, pc=0x8000_0180, state FETCH. Exception beats stall.
- Wrap and async reset:
  - pc=0xFFFF_FFFC gives out_PCplus4=0 and next pc=0.
  - RESET pulled low mid-cycle forces imem_req=0 and pc=RESET_PC with no clock edge.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, picks the next fetch address and
// presents either a fetched word or a NOP bubble to the IF/ID register.
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exception,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_PCplus4
);

    localparam logic [31:0] NOP_INST    = 32'h2000_0000;
    localparam logic [31:0] BUBBLE_PC4  = 32'hFFFF_FFFF;
    localparam logic [31:0] EXC_ALIGNED = {EXC_VECTOR[31:2], 2'b00};

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_hold_buf;
    logic [31:0] w_next_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_aligned;
    logic [31:0] w_jump_aligned;
    logic        w_hold_load;
    logic        w_req;
    logic        w_valid;

    assign w_pc_plus4       = r_pc + 32'd4;
    assign w_branch_aligned = {branch_target[31:2], 2'b00};
    assign w_jump_aligned   = {jump_target[31:2], 2'b00};

    // Next-state / next-PC selection; priority is exception > stall > branch > jump > sequential.
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_hold_load  = 1'b0;
        w_req        = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_next_state = ST_FETCH;
                if (exception) begin
                    w_next_pc = EXC_ALIGNED;
                end else begin
                    w_next_pc = r_pc;
                end
            end
            ST_FETCH: begin
                w_req   = 1'b1;
                w_valid = imem_ready & ~exception;
                if (exception) begin
                    w_next_pc = EXC_ALIGNED;
                end else if (stall) begin
                    if (imem_ready) begin
                        w_hold_load  = 1'b1;
                        w_next_state = ST_HELD;
                    end else begin
                        w_next_state = ST_FETCH;
                    end
                end else if (branch_taken) begin
                    w_next_pc = w_branch_aligned;
                end else if (jump) begin
                    w_next_pc = w_jump_aligned;
                end else if (imem_ready) begin
                    w_next_pc = w_pc_plus4;
                end else begin
                    w_next_pc = r_pc;
                end
            end
            ST_HELD: begin
                w_valid = ~exception;
                if (exception) begin
                    w_next_pc    = EXC_ALIGNED;
                    w_next_state = ST_FETCH;
                end else if (stall) begin
                    w_next_state = ST_HELD;
                end else if (branch_taken) begin
                    w_next_pc    = w_branch_aligned;
                    w_next_state = ST_FETCH;
                end else if (jump) begin
                    w_next_pc    = w_jump_aligned;
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_pc    = w_pc_plus4;
                    w_next_state = ST_FETCH;
                end
            end
            default: begin
                w_next_state = ST_BOOT;
                w_next_pc    = RESET_PC;
            end
        endcase
    end

    // State, PC and held-word registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_hold_buf <= NOP_INST;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            if (w_hold_load) begin
                r_hold_buf <= imem_rdata;
            end
        end
    end

    // IF/ID-facing outputs; the word source follows the state, bubbles otherwise.
    always_comb begin
        out_inst    = NOP_INST;
        out_PCplus4 = BUBBLE_PC4;
        if (w_valid) begin
            out_PCplus4 = w_pc_plus4;
            if (r_state == ST_HELD) begin
                out_inst = r_hold_buf;
            end else begin
                out_inst = imem_rdata;
            end
        end else begin
            out_inst    = NOP_INST;
            out_PCplus4 = BUBBLE_PC4;
        end
    end

    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign out_valid = w_valid;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: hand-computed PC / instruction / bubble values.
module tb_if_fetch;

    localparam logic [31:0] K   = 32'h1234_0000;
    localparam logic [31:0] NOP = 32'h2000_0000;
    localparam logic [31:0] BPC = 32'hFFFF_FFFF;
    localparam logic [31:0] EXC = 32'h8000_0180;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        stall, branch_taken, jump, exception, imem_ready, corrupt;
    logic [31:0] branch_target, jump_target;
    logic        imem_req, out_valid;
    logic [31:0] imem_addr, imem_rdata, out_inst, out_PCplus4;

    int n_cmp = 0;
    int n_err = 0;

    // Memory model: word = address ^ K, optionally scrambled to expose re-reads.
    assign imem_rdata = imem_addr ^ K ^ (corrupt ? 32'h0000_FFFF : 32'h0000_0000);

    always #5 CLK = ~CLK;

    if_fetch dut (
        .CLK(CLK), .RESET(RESET), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .exception(exception),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_inst(out_inst), .out_PCplus4(out_PCplus4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic vld, input logic [31:0] inst, input logic [31:0] pc4);
        #1;
        chk({tag, ".req"},  {31'd0, imem_req}, {31'd0, req});
        chk({tag, ".addr"}, imem_addr, addr);
        chk({tag, ".vld"},  {31'd0, out_valid}, {31'd0, vld});
        chk({tag, ".inst"}, out_inst, inst);
        chk({tag, ".pc4"},  out_PCplus4, pc4);
    endtask

    initial begin
        RESET = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; exception = 1'b0;
        imem_ready = 1'b1; corrupt = 1'b0; branch_target = 32'd0; jump_target = 32'd0;
        #3;
        chk_out("reset", 1'b0, 32'd0, 1'b0, NOP, BPC);
        tick();
        RESET = 1'b1;
        chk_out("boot", 1'b0, 32'd0, 1'b0, NOP, BPC);
        tick();
        chk_out("seq0", 1'b1, 32'd0, 1'b1, 32'd0 ^ K, 32'd4);
        tick();
        chk_out("seq4", 1'b1, 32'd4, 1'b1, 32'd4 ^ K, 32'd8);
        tick();
        imem_ready = 1'b0;
        chk_out("wait1", 1'b1, 32'd8, 1'b0, NOP, BPC);
        tick();
        chk_out("wait2", 1'b1, 32'd8, 1'b0, NOP, BPC);
        tick();
        imem_ready = 1'b1;
        chk_out("wdone", 1'b1, 32'd8, 1'b1, 32'd8 ^ K, 32'd12);
        tick();
        chk_out("seqC", 1'b1, 32'hC, 1'b1, 32'hC ^ K, 32'h10);
        tick();
        stall = 1'b1;
        chk_out("stall1", 1'b1, 32'h10, 1'b1, 32'h10 ^ K, 32'h14);
        tick();
        corrupt = 1'b1;
        chk_out("held2", 1'b0, 32'h10, 1'b1, 32'h10 ^ K, 32'h14);
        tick();
        chk_out("held3", 1'b0, 32'h10, 1'b1, 32'h10 ^ K, 32'h14);
        stall = 1'b0;
        chk_out("hrel", 1'b0, 32'h10, 1'b1, 32'h10 ^ K, 32'h14);
        tick();
        corrupt = 1'b0;
        chk_out("after", 1'b1, 32'h14, 1'b1, 32'h14 ^ K, 32'h18);
        tick(); tick(); tick();
        branch_taken = 1'b1; jump = 1'b1;
        branch_target = 32'h0000_0103; jump_target = 32'h0000_0200;
        chk_out("br", 1'b1, 32'h20, 1'b1, 32'h20 ^ K, 32'h24);
        tick();
        branch_taken = 1'b0; jump = 1'b0;
        chk_out("brtgt", 1'b1, 32'h100, 1'b1, 32'h100 ^ K, 32'h104);
        stall = 1'b1;
        tick();
        exception = 1'b1;
        chk_out("exheld", 1'b0, 32'h100, 1'b0, NOP, BPC);
        tick();
        exception = 1'b0; stall = 1'b0;
        chk_out("exvec", 1'b1, EXC, 1'b1, EXC ^ K, EXC + 32'd4);
        jump = 1'b1; jump_target = 32'hFFFF_FFFE;
        tick();
        jump = 1'b0;
        chk_out("wrap", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC ^ K, 32'd0);
        tick();
        chk_out("wrap0", 1'b1, 32'd0, 1'b1, 32'd0 ^ K, 32'd4);
        exception = 1'b1;
        chk_out("exfetch", 1'b1, 32'd0, 1'b0, NOP, BPC);
        tick();
        exception = 1'b0;
        chk_out("exf2", 1'b1, EXC, 1'b1, EXC ^ K, EXC + 32'd4);
        tick();
        chk({"pre_rst.addr"}, imem_addr, EXC + 32'd4);
        #2;
        RESET = 1'b0;
        chk_out("async", 1'b0, 32'd0, 1'b0, NOP, BPC);
        tick();
        exception = 1'b1;
        RESET = 1'b1;
        chk_out("boot2", 1'b0, 32'd0, 1'b0, NOP, BPC);
        tick();
        exception = 1'b0;
        chk_out("bootexc", 1'b1, EXC, 1'b1, EXC ^ K, EXC + 32'd4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
